// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_MAX = 7;
  localparam logic [2:0]  FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
  typedef enum logic [1:0] {IDLE, BUSY, LAST} state_e;

  // The latency countdown doubles as the state encoding.
  function automatic state_e cnt_to_state(input logic [2:0] cnt);
    if (cnt == 3'd0) begin
      return IDLE;
    end else if (cnt == 3'd1) begin
      return LAST;
    end
    return BUSY;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-way combinational pick between fetch and data; prio_d_i breaks ties.
module arb_pick (
  input  logic req_if_i,
  input  logic req_d_i,
  input  logic prio_d_i,
  output logic gnt_if_o,
  output logic gnt_d_o
);

  always_comb begin
    gnt_d_o  = req_d_i & (prio_d_i | ~req_if_i);
    gnt_if_o = req_if_i & ~gnt_d_o;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of fixed D-over-IF priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LatCnt = 3'(MEM_LAT);

  logic [2:0]  cnt_q, cnt_d;
  owner_e      owner_q, owner_d;
  logic        we_q, we_d;
  state_e      state;
  logic        can_grant;
  logic        prio_d;
  logic        pick_if, pick_d;
  logic        rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  assign state     = cnt_to_state(cnt_q);
  // No grants while reset is high so an accepted command is never silently dropped.
  assign can_grant = ~reset & (state != BUSY);
  assign busy      = (cnt_q != 3'd0);

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  assign prio_d = ~last_d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else if (pick_if | pick_d) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign prio_d = 1'b1;
`endif

  arb_pick u_pick (
    .req_if_i (if_req & can_grant),
    .req_d_i  (d_req & can_grant),
    .prio_d_i (prio_d),
    .gnt_if_o (pick_if),
    .gnt_d_o  (pick_d)
  );

  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    owner_d    = owner_q;
    we_d       = we_q;
    cnt_d      = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;

    if (pick_d) begin
      d_gnt      = 1'b1;
      mem_en     = 1'b1;
      mem_we     = d_we;
      mem_funct3 = d_funct3;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
      owner_d    = OWN_D;
      we_d       = d_we;
      cnt_d      = LatCnt;
    end else if (pick_if) begin
      if_gnt     = 1'b1;
      mem_en     = 1'b1;
      mem_funct3 = FETCH_FUNCT3;
      mem_addr   = if_addr;
      owner_d    = OWN_IF;
      we_d       = 1'b0;
      cnt_d      = LatCnt;
    end else if (state == LAST) begin
      owner_d = OWN_NONE;
    end
  end

  // Response is owned by the transaction in LAST; reset suppresses it.
  always_comb begin
    rsp_valid = (state == LAST) & ~reset;
    rsp_data  = we_q ? '0 : mem_rdata;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (rsp_valid && owner_q == OWN_IF) begin
      if_rvalid = 1'b1;
      if_rdata  = rsp_data;
    end
    if (rsp_valid && owner_q == OWN_D) begin
      d_rvalid = 1'b1;
      d_rdata  = rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 3'd0;
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
    end
  end

endmodule
